// File: rtl/mcp3221_i2c_pkg.sv
// Shared types and constants for the MCP3221-style I2C read responder.
package mcp3221_i2c_pkg;

  localparam int unsigned C_DATA_WIDTH = 16;
  localparam int unsigned C_BYTE_BITS  = 8;
  localparam int unsigned C_ADDR_W     = 7;
  localparam int unsigned C_BIT_CNT_W  = 4;
  localparam int unsigned C_COUNT_W    = 8;

  typedef enum logic [2:0] {
    SM_idle,
    SM_get_address,
    SM_ack_address,
    SM_send_data,
    SM_get_master_ack,
    SM_wait_stop
  } sm_state_t;

  // Per-transaction status payload
  typedef struct packed {
    logic [C_COUNT_W-1:0] bytes_sent;
    logic                 master_nack;
  } status_t;

  function automatic logic [C_COUNT_W-1:0] sat_inc(input logic [C_COUNT_W-1:0] v);
    return (v == {C_COUNT_W{1'b1}}) ? v : v + C_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA and flags SCL edges plus START/STOP conditions.
// Optional majority filter enabled by MCP3221_I2C_RESPONDER_GLITCH_FILTER_EN.
module i2c_bus_monitor (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_flt;
  logic       sda_flt;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_rise_q;
  logic       scl_fall_q;
  logic       start_q;
  logic       stop_q;
  logic       sda_q;

  // Idle bus is high, so reset the pipeline high to avoid false edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef MCP3221_I2C_RESPONDER_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q;
  logic [2:0] sda_hist_q;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
    end
  end

  assign scl_flt = majority3(scl_hist_q);
  assign sda_flt = majority3(sda_hist_q);
`else
  assign scl_flt = scl_sync_q[1];
  assign sda_flt = sda_sync_q[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_prev_q <= scl_flt;
      sda_prev_q <= sda_flt;
      scl_rise_q <= scl_flt & ~scl_prev_q;
      scl_fall_q <= ~scl_flt & scl_prev_q;
      start_q    <= scl_flt & scl_prev_q & sda_prev_q & ~sda_flt;
      stop_q     <= scl_flt & scl_prev_q & ~sda_prev_q & sda_flt;
      sda_q      <= sda_flt;
    end
  end

  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign sda_o      = sda_q;

endmodule

// File: rtl/mcp3221_i2c_responder.sv
// I2C read-only responder serving a 16-bit sample word, MCP3221 style.
// Build option MCP3221_I2C_RESPONDER_GLITCH_FILTER_EN adds a bus glitch filter.
module mcp3221_i2c_responder
  import mcp3221_i2c_pkg::*;
#(
  parameter logic [C_ADDR_W-1:0] G_DEVICE_ADDRESS = 7'h4D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [C_DATA_WIDTH-1:0] din_register_data,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    i2c_sclk,
  input  logic                    i2c_sda_input,
  output logic                    i2c_sda_output,
  output logic                    sda_is_output,
  output logic [C_COUNT_W-1:0]    dout_bytes_sent,
  output logic                    dout_master_nack,
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  localparam logic [C_BIT_CNT_W-1:0] C_LAST_BIT = C_BIT_CNT_W'(C_BYTE_BITS);

  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;
  logic sda_s;

  sm_state_t                state_q,    state_d;
  logic [C_BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [C_BYTE_BITS-1:0]   addr_q,     addr_d;
  logic [C_DATA_WIDTH-1:0]  shift_q,    shift_d;
  logic                     sda_oe_q,   sda_oe_d;
  logic                     byte_idx_q, byte_idx_d;
  status_t                  trans_q,    trans_d;
  status_t                  dout_q,     dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic [C_DATA_WIDTH-1:0]  hold_q;
  logic                     din_ready_q;
  logic                     post_c;

  i2c_bus_monitor u_bus_monitor (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (i2c_sclk),
    .sda_i      (i2c_sda_input),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop),
    .sda_o      (sda_s)
  );

  // Holding register loads whenever a word is offered; shift register is independent
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      din_ready_q <= 1'b0;
    end else begin
      din_ready_q <= 1'b1;
      if (din_valid && din_ready_q) begin
        hold_q <= din_register_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SM_idle;
      bit_cnt_q    <= '0;
      addr_q       <= '0;
      shift_q      <= '0;
      sda_oe_q     <= 1'b0;
      byte_idx_q   <= 1'b0;
      trans_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      addr_q       <= addr_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      byte_idx_q   <= byte_idx_d;
      trans_q      <= trans_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    addr_d       = addr_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    byte_idx_d   = byte_idx_q;
    trans_d      = trans_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !dout_ready;
    post_c       = 1'b0;

    case (state_q)
      SM_get_address: begin
        if (scl_rise) begin
          addr_d    = {addr_q[C_BYTE_BITS-2:0], sda_s};
          bit_cnt_d = bit_cnt_q + C_BIT_CNT_W'(1);
        end else if (scl_fall && bit_cnt_q == C_LAST_BIT) begin
          bit_cnt_d = '0;
          if (addr_q == {G_DEVICE_ADDRESS, 1'b1}) begin
            sda_oe_d   = 1'b1;
            shift_d    = hold_q;
            byte_idx_d = 1'b0;
            state_d    = SM_ack_address;
          end else begin
            state_d = SM_wait_stop;
          end
        end
      end

      // Ninth falling edge ends the ACK and puts out the first data bit
      SM_ack_address: begin
        if (scl_fall) begin
          sda_oe_d  = ~shift_q[C_DATA_WIDTH-1];
          shift_d   = {shift_q[C_DATA_WIDTH-2:0], 1'b0};
          bit_cnt_d = C_BIT_CNT_W'(1);
          state_d   = SM_send_data;
        end
      end

      SM_send_data: begin
        if (scl_fall) begin
          if (bit_cnt_q == C_LAST_BIT) begin
            sda_oe_d = 1'b0;
            state_d  = SM_get_master_ack;
          end else begin
            sda_oe_d  = ~shift_q[C_DATA_WIDTH-1];
            shift_d   = {shift_q[C_DATA_WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + C_BIT_CNT_W'(1);
          end
        end
      end

      // After the second byte is acknowledged the word is re-sampled
      SM_get_master_ack: begin
        if (scl_rise) begin
          trans_d.bytes_sent = sat_inc(trans_q.bytes_sent);
          bit_cnt_d          = '0;
          if (sda_s) begin
            trans_d.master_nack = 1'b1;
            state_d             = SM_wait_stop;
          end else begin
            if (byte_idx_q) begin
              shift_d = hold_q;
            end
            byte_idx_d = ~byte_idx_q;
            state_d    = SM_send_data;
          end
        end
      end

      default: ;
    endcase

    // A repeated START also closes the current transaction's status
    if (bus_start) begin
      state_d   = SM_get_address;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      post_c    = (trans_q.bytes_sent != '0);
      trans_d   = '0;
    end else if (bus_stop) begin
      state_d  = SM_idle;
      sda_oe_d = 1'b0;
      post_c   = (trans_q.bytes_sent != '0);
      trans_d  = '0;
    end

    if (post_c) begin
      dout_d       = trans_q;
      dout_valid_d = 1'b1;
    end
  end

  assign din_ready        = din_ready_q;
  assign i2c_sda_output   = 1'b0;
  assign sda_is_output    = sda_oe_q;
  assign dout_bytes_sent  = dout_q.bytes_sent;
  assign dout_master_nack = dout_q.master_nack;
  assign dout_valid       = dout_valid_q;

endmodule

// File: tb/tb_mcp3221_i2c_responder.sv
// Directed bench for the MCP3221 I2C responder with a status scoreboard.
module tb_mcp3221_i2c_responder;
  import mcp3221_i2c_pkg::*;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din_register_data;
  logic        din_valid;
  logic        din_ready;
  logic        i2c_sclk;
  logic        sda_m;
  logic        sda_bus;
  logic        i2c_sda_output;
  logic        sda_is_output;
  logic [7:0]  dout_bytes_sent;
  logic        dout_master_nack;
  logic        dout_valid;
  logic        dout_ready;

  int      total = 0;
  int      bad   = 0;
  logic    sda_seen;
  status_t exp_q[$];
  status_t e;

  always #5 clk = ~clk;

  assign sda_bus = sda_is_output ? (sda_m & i2c_sda_output) : sda_m;

  mcp3221_i2c_responder dut (
    .clk               (clk),
    .reset             (reset),
    .din_register_data (din_register_data),
    .din_valid         (din_valid),
    .din_ready         (din_ready),
    .i2c_sclk          (i2c_sclk),
    .i2c_sda_input     (sda_bus),
    .i2c_sda_output    (i2c_sda_output),
    .sda_is_output     (sda_is_output),
    .dout_bytes_sent   (dout_bytes_sent),
    .dout_master_nack  (dout_master_nack),
    .dout_valid        (dout_valid),
    .dout_ready        (dout_ready)
  );

  // Scoreboard monitor: every status handshake pops one expected entry
  always @(negedge clk) begin
    if (sda_is_output) sda_seen = 1'b1;
    if (reset && dout_valid && dout_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL status_unexpected: got bytes=%0d nack=%0d, required no post",
                 dout_bytes_sent, dout_master_nack);
      end else begin
        e = exp_q.pop_front();
        if (dout_bytes_sent !== e.bytes_sent || dout_master_nack !== e.master_nack) begin
          bad++;
          $display("FAIL status: got bytes=%0d nack=%0d, required bytes=%0d nack=%0d",
                   dout_bytes_sent, dout_master_nack, e.bytes_sent, e.master_nack);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [15:0] w);
    din_register_data = w;
    din_valid = 1'b1;
    wait_clk(1);
    din_valid = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;    wait_clk(Q);
    i2c_sclk = 1'b1; wait_clk(Q);
    sda_m = 1'b0;    wait_clk(Q);
    i2c_sclk = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;    wait_clk(Q);
    i2c_sclk = 1'b1; wait_clk(Q);
    sda_m = 1'b1;    wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;       wait_clk(Q);
    i2c_sclk = 1'b1; wait_clk(2 * Q);
    i2c_sclk = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;    wait_clk(Q);
    i2c_sclk = 1'b1; wait_clk(Q);
    b = sda_bus;     wait_clk(Q);
    i2c_sclk = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  // START, address phase and the responder's ACK bit
  task automatic address(input logic [7:0] a, input int exp_ack_level, input string name);
    logic b;
    i2c_start();
    write_byte(a);
    read_bit(b);
    chk(name, int'(b), exp_ack_level);
  endtask

  initial begin
    logic [7:0] rd;
    logic       b;
    reset = 1'b0;
    din_register_data = '0;
    din_valid = 1'b0;
    i2c_sclk = 1'b1;
    sda_m = 1'b1;
    dout_ready = 1'b1;
    sda_seen = 1'b0;
    wait_clk(4);

    chk("rst_sda_is_output", int'(sda_is_output), 0);
    chk("rst_sda_output", int'(i2c_sda_output), 0);
    chk("rst_din_ready", int'(din_ready), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_bytes_sent", int'(dout_bytes_sent), 0);
    chk("rst_master_nack", int'(dout_master_nack), 0);
    reset = 1'b1;
    wait_clk(4);
    chk("din_ready_after_reset", int'(din_ready), 1);

    // Two-byte read of 0x0ABC, NACK, status held while dout_ready is low
    load_word(16'h0ABC);
    dout_ready = 1'b0;
    exp_q.push_back('{bytes_sent: 8'd2, master_nack: 1'b1});
    address(8'h9B, 0, "read_ack_4d");
    read_byte(rd); chk("rd1_byte1", int'(rd), 'h0A);
    write_bit(1'b0);
    read_byte(rd); chk("rd1_byte2", int'(rd), 'hBC);
    write_bit(1'b1);
    i2c_stop();
    wait_clk(20);
    chk("dout_valid_held", int'(dout_valid), 1);
    chk("held_bytes_sent", int'(dout_bytes_sent), 2);
    dout_ready = 1'b1;
    wait_clk(4);
    chk("dout_valid_cleared", int'(dout_valid), 0);

    // Foreign address 0x4C: bus never driven, no status
    sda_seen = 1'b0;
    address(8'h99, 1, "nack_addr_4c");
    read_byte(rd); chk("foreign_read_ff", int'(rd), 'hFF);
    write_bit(1'b1);
    i2c_stop();
    wait_clk(Q);
    chk("foreign_sda_never_driven", int'(sda_seen), 0);

    // Write request to own address is not acknowledged
    address(8'h9A, 1, "nack_write_4d");
    chk("write_wait_stop", int'(dut.state_q), int'(SM_wait_stop));
    i2c_stop();
    wait_clk(Q);
    chk("write_stop_idle", int'(dut.state_q), int'(SM_idle));

    // Four-byte read with a reload after byte 1
    exp_q.push_back('{bytes_sent: 8'd4, master_nack: 1'b1});
    address(8'h9B, 0, "read4_ack");
    read_byte(rd); chk("rd4_byte1", int'(rd), 'h0A);
    write_bit(1'b0);
    load_word(16'h0123);
    read_byte(rd); chk("rd4_byte2", int'(rd), 'hBC);
    write_bit(1'b0);
    read_byte(rd); chk("rd4_byte3", int'(rd), 'h01);
    write_bit(1'b0);
    read_byte(rd); chk("rd4_byte4", int'(rd), 'h23);
    write_bit(1'b1);
    i2c_stop();
    wait_clk(2 * Q);

    // Repeated START after one byte, then a fresh two-byte read
    exp_q.push_back('{bytes_sent: 8'd1, master_nack: 1'b1});
    exp_q.push_back('{bytes_sent: 8'd2, master_nack: 1'b1});
    address(8'h9B, 0, "rs_first_ack");
    read_byte(rd); chk("rs_first_byte", int'(rd), 'h01);
    write_bit(1'b1);
    address(8'h9B, 0, "rs_second_ack");
    read_byte(rd); chk("rs_byte1", int'(rd), 'h01);
    write_bit(1'b0);
    read_byte(rd); chk("rs_byte2", int'(rd), 'h23);
    write_bit(1'b1);
    i2c_stop();
    wait_clk(2 * Q);

    // Reset while bit 4 of byte 1 (a 0 bit of 0x01) is on the bus
    address(8'h9B, 0, "rst_mid_ack");
    for (int i = 0; i < 3; i++) read_bit(b);
    chk("bit4_driven_low", int'(sda_is_output), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_sda_released", int'(sda_is_output), 0);
    chk("mid_rst_din_ready", int'(din_ready), 0);
    chk("mid_rst_dout_valid", int'(dout_valid), 0);
    chk("mid_rst_bytes_sent", int'(dout_bytes_sent), 0);
    chk("mid_rst_master_nack", int'(dout_master_nack), 0);
    chk("mid_rst_hold", int'(dut.hold_q), 0);
    chk("mid_rst_state", int'(dut.state_q), int'(SM_idle));
    sda_m = 1'b1;
    wait_clk(Q);
    i2c_sclk = 1'b1;
    wait_clk(Q);
    reset = 1'b1;
    wait_clk(Q);
    chk("post_rst_idle", int'(dut.state_q), int'(SM_idle));
    load_word(16'h0ABC);
    exp_q.push_back('{bytes_sent: 8'd1, master_nack: 1'b1});
    address(8'h9B, 0, "resume_ack");
    read_byte(rd); chk("resume_byte1", int'(rd), 'h0A);
    write_bit(1'b1);
    i2c_stop();

    wait_clk(50);
    chk("status_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
